// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, fetch state encoding and reset PC.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE
    } fetch_state_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/npc_calc.sv
// Next-PC selection: illegal fallthrough, then jump, then taken branch, else pc+4.
module npc_calc (
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        jump,
    input  logic        branch,
    input  logic        alu_zero,
    input  logic        illegal,
    output logic [31:0] npc
);

    logic signed [31:0] br_off;
    logic               unused_opcode;

    assign br_off        = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign unused_opcode = ^instr[31:26];

    // Illegal opcodes ignore jump/branch entirely since the decoder leaves them undefined.
    always_comb begin
        npc = pc_plus4;
        if (illegal) begin
            npc = pc_plus4;
        end else if (jump) begin
            npc = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (branch && alu_zero) begin
            npc = pc_plus4 + $unsigned(br_off);
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fetches over req/ready/rvalid and
// retires each instruction on instr_ack by loading the computed next PC.
module ifetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        func,
    input  logic              instr_ack,
    input  logic              jump,
    input  logic              branch,
    input  logic              alu_zero,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              illegal_op
);

    fetch_state_t state, state_nx;
    logic [31:0]  npc;
    logic         illegal;
    logic         retire;

    assign opcode    = instr[31:26];
    assign func      = instr[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign imem_addr = pc;
    assign illegal   = !op_legal(opcode);
    assign retire    = (state == S_ISSUE) && instr_ack;

    npc_calc u_npc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr),
        .jump     (jump),
        .branch   (branch),
        .alu_zero (alu_zero),
        .illegal  (illegal),
        .npc      (npc)
    );

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        case (state)
            S_IDLE:  state_nx = S_REQ;
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ready) state_nx = S_WAIT;
            end
            S_WAIT:  if (imem_rvalid) state_nx = S_ISSUE;
            S_ISSUE: if (instr_ack) state_nx = S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Instruction capture in S_WAIT, retirement and PC update in S_ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_valid <= 1'b0;
            illegal_op  <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            if (state == S_WAIT && imem_rvalid) begin
                instr       <= imem_rdata;
                instr_valid <= 1'b1;
            end
            if (retire) begin
                pc          <= npc;
                instr_valid <= 1'b0;
                illegal_op  <= illegal;
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: two instances (reset PC 0 and 0x8000_0000) share
// stimulus and are checked every cycle against a transaction-level model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ack = 1'b0;
    logic        jump = 1'b0;
    logic        branch = 1'b0;
    logic        alu_zero = 1'b0;

    logic        imem_req, instr_valid, illegal_op;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode, func;

    logic        imem_req_hi, instr_valid_hi, illegal_op_hi;
    logic [31:0] imem_addr_hi, instr_hi, pc_hi, pc_plus4_hi;
    logic [5:0]  opcode_hi, func_hi;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    ifetch_unit u_dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .opcode(opcode), .func(func),
        .instr_ack(instr_ack), .jump(jump), .branch(branch), .alu_zero(alu_zero),
        .pc(pc), .pc_plus4(pc_plus4), .illegal_op(illegal_op)
    );

    ifetch_unit #(.RESET_PC(32'h8000_0000)) u_dut_hi (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req_hi), .imem_addr(imem_addr_hi), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid_hi), .instr(instr_hi), .opcode(opcode_hi), .func(func_hi),
        .instr_ack(instr_ack), .jump(jump), .branch(branch), .alu_zero(alu_zero),
        .pc(pc_hi), .pc_plus4(pc_plus4_hi), .illegal_op(illegal_op_hi)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic legal_op(input logic [5:0] op);
        return (op == 6'd0) || (op == 6'd35) || (op == 6'd43) || (op == 6'd4) || (op == 6'd2);
    endfunction

    function automatic logic [31:0] model_npc(input logic [31:0] p, input logic [31:0] w,
                                              input logic j, input logic b, input logic z);
        longint t;
        if (!legal_op(w[31:26])) return p + 32'd4;
        if (j === 1'b1) return ((p + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 32'd4);
        if (b === 1'b1 && z === 1'b1) begin
            t = longint'(p) + 64'sd4 + longint'($signed(w[15:0])) * 64'sd4;
            return t[31:0];
        end
        return p + 32'd4;
    endfunction

    logic [31:0] m_pc = 32'h0, m_pc_hi = 32'h8000_0000, m_instr = 32'h0;
    logic        m_valid = 1'b0, m_req = 1'b0, m_wait = 1'b0, m_ill = 1'b0, m_started = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc <= 32'h0; m_pc_hi <= 32'h8000_0000; m_instr <= 32'h0;
            m_valid <= 1'b0; m_req <= 1'b0; m_wait <= 1'b0; m_ill <= 1'b0; m_started <= 1'b0;
        end else begin
            m_ill <= 1'b0;
            if (!m_started) begin
                m_started <= 1'b1;
                m_req     <= 1'b1;
            end else if (m_req) begin
                if (imem_ready) begin m_req <= 1'b0; m_wait <= 1'b1; end
            end else if (m_wait) begin
                if (imem_rvalid) begin m_wait <= 1'b0; m_valid <= 1'b1; m_instr <= imem_rdata; end
            end else if (m_valid && instr_ack) begin
                m_valid <= 1'b0;
                m_req   <= 1'b1;
                m_pc    <= model_npc(m_pc, m_instr, jump, branch, alu_zero);
                m_pc_hi <= model_npc(m_pc_hi, m_instr, jump, branch, alu_zero);
                m_ill   <= !legal_op(m_instr[31:26]);
            end
        end
    end

    always @(negedge clk) begin
        chk("req", imem_req, m_req);
        chk("req_hi", imem_req_hi, m_req);
        chk("pc", pc, m_pc);
        chk("pc_hi", pc_hi, m_pc_hi);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("pc_plus4_hi", pc_plus4_hi, m_pc_hi + 32'd4);
        chk("instr_valid", instr_valid, m_valid);
        chk("instr_valid_hi", instr_valid_hi, m_valid);
        chk("illegal_op", illegal_op, m_ill);
        chk("illegal_op_hi", illegal_op_hi, m_ill);
        if (m_req) begin
            chk("addr", imem_addr, m_pc);
            chk("addr_hi", imem_addr_hi, m_pc_hi);
        end
        if (m_valid) begin
            chk("instr", instr, m_instr);
            chk("opcode", opcode, {26'd0, m_instr[31:26]});
            chk("func", func, {26'd0, m_instr[5:0]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_req();
        int guard = 0;
        while (imem_req !== 1'b1 && guard < 20) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("req_timeout", imem_req, 32'd1);
    endtask

    task automatic fetch(input logic [31:0] w, input int rdly, input logic j, input logic b,
                         input logic z, input logic [31:0] exp_a, input logic [31:0] exp_h);
        wait_req();
        chk("fetch_addr", imem_addr, exp_a);
        chk("fetch_addr_hi", imem_addr_hi, exp_h);
        for (int k = 0; k < rdly; k++) begin
            imem_ready = 1'b0;
            @(posedge clk); #2;
            chk("bp_req", imem_req, 32'd1);
            chk("bp_addr", imem_addr, exp_a);
        end
        imem_ready = 1'b1;
        @(posedge clk); #2;
        imem_ready = 1'b0;
        chk("wait_req_low", imem_req, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = w;
        @(posedge clk); #2;
        imem_rvalid = 1'b0;
        chk("issue_valid", instr_valid, 32'd1);
        chk("issue_instr", instr, w);
        instr_ack = 1'b1; jump = j; branch = b; alu_zero = z;
        @(posedge clk); #2;
        instr_ack = 1'b0; jump = 1'b0; branch = 1'b0; alu_zero = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pc_hi", pc_hi, 32'h8000_0000);
        chk("rst_instr", instr, 32'h0);
        chk("rst_valid", instr_valid, 32'd0);
        chk("rst_req", imem_req, 32'd0);
        rst_n = 1'b1;
        chk("req_at_release", imem_req, 32'd0);
        @(posedge clk); #2;
        chk("req_one_after", imem_req, 32'd1);

        fetch(32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000);
        fetch(32'h8C01_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h8000_0004);
        fetch(32'hAC01_0000, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 32'h8000_0008);
        fetch(32'h0800_0008, 0, 1'b1, 1'b0, 1'b0, 32'h0000_000C, 32'h8000_000C);
        fetch(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0020, 32'h8000_0020);
        fetch(32'h0800_0004, 0, 1'b1, 1'b0, 1'b0, 32'h0000_001C, 32'h8000_001C);
        fetch(32'h1000_0003, 3, 1'b0, 1'b1, 1'b1, 32'h0000_0010, 32'h8000_0010);
        fetch(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b0, 32'h0000_0020, 32'h8000_0020);
        fetch(32'hFC00_0000, 0, 1'bx, 1'bx, 1'bx, 32'h0000_0024, 32'h8000_0024);
        chk("illegal_pulse", illegal_op, 32'd1);
        @(posedge clk); #2;
        chk("illegal_clear", illegal_op, 32'd0);
        chk("pc_known", {31'd0, $isunknown(pc)}, 32'd0);
        fetch(32'h1000_FFF4, 0, 1'b0, 1'b1, 1'b1, 32'h0000_0028, 32'h8000_0028);
        fetch(32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h7FFF_FFFC);

        wait_req();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        chk("wrap_addr_hi", imem_addr_hi, 32'h8000_0000);
        imem_ready = 1'b1;
        @(posedge clk); #2;
        imem_ready = 1'b0;
        rst_n = 1'b0;
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", instr_valid, 32'd0);
        chk("midrst_req", imem_req, 32'd0);
        @(posedge clk); #2;
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #2;
        chk("late_rvalid_valid", instr_valid, 32'd0);
        chk("late_rvalid_req", imem_req, 32'd1);
        @(posedge clk); #2;
        imem_rvalid = 1'b0;
        chk("late_rvalid_valid2", instr_valid, 32'd0);
        chk("late_rvalid_pc", pc, 32'h0);

        fetch(32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 32'h0000_0000, 32'h8000_0000);
        wait_req();
        chk("jump_addr", imem_addr, 32'h0000_0100);
        chk("jump_addr_hi", imem_addr_hi, 32'h8000_0100);

        repeat (2) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
